// File: rtl/uart_pkg.sv
// Shared definitions for the system-bus UART receiver: register offsets, status bits and
// receiver FSM states.
package uart_pkg;

    localparam logic [23:0] ADDR_DATA     = 24'h00;
    localparam logic [23:0] ADDR_VALID    = 24'h04;
    localparam logic [23:0] ADDR_BUSY     = 24'h08;
    localparam logic [23:0] ADDR_DIV      = 24'h0C;
    localparam logic [23:0] ADDR_PARITY   = 24'h10;
    localparam logic [23:0] ADDR_STOPBITS = 24'h14;
    localparam logic [23:0] ADDR_STATUS   = 24'h18;
    localparam logic [23:0] ADDR_RST      = 24'h24;

    localparam int unsigned STATUS_OVR = 0;
    localparam int unsigned STATUS_FRM = 1;
    localparam int unsigned STATUS_PAR = 2;

    localparam int unsigned MIN_DIV = 16;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StPar,
        StStop
    } rx_state_e;

endpackage

// File: rtl/uart_rx.sv
// UART receive engine: rx synchroniser, bit-timing counter, frame FSM and shift register.
// Emits single-cycle pulses for a completed byte, a frame error and a parity error.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DIV_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_rx,
    input  logic [DIV_W-1:0] i_div,
    input  logic [DIV_W-1:0] i_div_sh,
    input  logic             i_par_en_sh,
    input  logic             i_stop2_sh,
    output logic             o_cfg_load,
    output logic [7:0]       o_byte,
    output logic             o_byte_valid,
    output logic             o_frame_err,
    output logic             o_parity_err,
    output logic             o_busy
);

    rx_state_e        r_state, w_state_nxt;
    logic [DIV_W-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]       r_bit, w_bit_nxt;
    logic [7:0]       r_shift, w_shift_nxt;
    logic             r_stop_idx, w_stop_idx_nxt;
    logic [1:0]       r_sync;
    logic             r_rx_prev;

    logic             w_rx;
    logic             w_fall;
    logic [DIV_W-1:0] w_target;
    logic             w_tick;

    assign w_rx   = r_sync[1];
    assign w_fall = r_rx_prev & ~w_rx;
    // Start bit is checked at mid-bit with the live divider; later bits use the frame's shadow.
    assign w_target = (r_state == StStart) ? (i_div >> 1) : (i_div_sh - 1'b1);
    assign w_tick   = (r_cnt == w_target);

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt + 1'b1;
        w_bit_nxt      = r_bit;
        w_shift_nxt    = r_shift;
        w_stop_idx_nxt = r_stop_idx;
        o_cfg_load     = 1'b0;
        o_byte_valid   = 1'b0;
        o_frame_err    = 1'b0;
        o_parity_err   = 1'b0;
        case (r_state)
            StIdle: begin
                w_cnt_nxt = '0;
                if (w_fall) w_state_nxt = StStart;
            end
            StStart: begin
                if (w_tick) begin
                    w_cnt_nxt = '0;
                    if (!w_rx) begin
                        w_state_nxt = StData;
                        w_bit_nxt   = 3'd0;
                        o_cfg_load  = 1'b1;
                    end else begin
                        w_state_nxt = StIdle;
                    end
                end
            end
            StData: begin
                if (w_tick) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {w_rx, r_shift[7:1]};
                    w_bit_nxt   = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        w_state_nxt    = i_par_en_sh ? StPar : StStop;
                        w_stop_idx_nxt = 1'b0;
                    end
                end
            end
            StPar: begin
                if (w_tick) begin
                    w_cnt_nxt      = '0;
                    o_parity_err   = (^r_shift) != w_rx;
                    w_state_nxt    = StStop;
                    w_stop_idx_nxt = 1'b0;
                end
            end
            StStop: begin
                if (w_tick) begin
                    w_cnt_nxt = '0;
                    if (!w_rx) begin
                        o_frame_err = 1'b1;
                        w_state_nxt = StIdle;
                    end else if (i_stop2_sh && !r_stop_idx) begin
                        w_stop_idx_nxt = 1'b1;
                    end else begin
                        o_byte_valid = 1'b1;
                        w_state_nxt  = StIdle;
                    end
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_stop_idx <= 1'b0;
            r_sync     <= 2'b11;
            r_rx_prev  <= 1'b1;
        end else if (i_clr) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_stop_idx <= 1'b0;
            r_sync     <= 2'b11;
            r_rx_prev  <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_bit      <= w_bit_nxt;
            r_shift    <= w_shift_nxt;
            r_stop_idx <= w_stop_idx_nxt;
            r_sync     <= {r_sync[0], i_rx};
            r_rx_prev  <= w_rx;
        end
    end

    assign o_byte = r_shift;
    assign o_busy = (r_state != StIdle);

endmodule

// File: rtl/uart_rx_sb_ctrl.sv
// System-bus UART receiver peripheral: register file, per-frame config shadowing, sticky
// status flags and the registered read path. irq follows VALID.
module uart_rx_sb_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned DEFAULT_DIV = 1042,
    parameter int unsigned DIV_W       = 16
) (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        req_i,
    input  logic        write_enable_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] write_data_i,
    output logic [31:0] read_data_o,
    input  logic        rx_i,
    output logic        irq_req_o
);

    logic [7:0]       r_data;
    logic             r_valid;
    logic [2:0]       r_status;
    logic [DIV_W-1:0] r_div, r_div_sh;
    logic             r_par_en, r_par_en_sh;
    logic             r_stop2, r_stop2_sh;
    logic [31:0]      r_rdata;

    logic [23:0]      w_off;
    logic             w_rd, w_wr, w_data_rd, w_soft_rst;
    logic [DIV_W-1:0] w_div_wr;
    logic [31:0]      w_rmux;
    logic [2:0]       w_status_clr, w_status_set;
    logic             w_cfg_load, w_byte_valid, w_frame_err, w_parity_err, w_busy;
    logic [7:0]       w_byte;
    logic             w_unused_bits;

    assign w_unused_bits = ^{addr_i[31:24], write_data_i[31:DIV_W]};

    assign w_off      = addr_i[23:0];
    assign w_rd       = req_i & ~write_enable_i;
    assign w_wr       = req_i & write_enable_i;
    assign w_data_rd  = w_rd && (w_off == ADDR_DATA);
    assign w_soft_rst = w_wr && (w_off == ADDR_RST) && write_data_i[0];
    assign w_div_wr   = (write_data_i[DIV_W-1:0] < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV)
                                                                     : write_data_i[DIV_W-1:0];

    always_comb begin
        w_rmux = '0;
        case (w_off)
            ADDR_DATA:     w_rmux[7:0]       = r_data;
            ADDR_VALID:    w_rmux[0]         = r_valid;
            ADDR_BUSY:     w_rmux[0]         = w_busy;
            ADDR_DIV:      w_rmux[DIV_W-1:0] = r_div;
            ADDR_PARITY:   w_rmux[0]         = r_par_en;
            ADDR_STOPBITS: w_rmux[0]         = r_stop2;
            ADDR_STATUS:   w_rmux[2:0]       = r_status;
            default:       w_rmux            = '0;
        endcase
    end

    always_comb begin
        w_status_clr = (w_wr && (w_off == ADDR_STATUS)) ? write_data_i[2:0] : 3'b000;
        w_status_set = '0;
        // A read of DATA in the commit cycle consumes the old byte, so it is not an overrun.
        w_status_set[STATUS_OVR] = w_byte_valid && r_valid && !w_data_rd;
        w_status_set[STATUS_FRM] = w_frame_err;
        w_status_set[STATUS_PAR] = w_parity_err;
    end

    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_status    <= '0;
            r_div       <= DIV_W'(DEFAULT_DIV);
            r_par_en    <= 1'b0;
            r_stop2     <= 1'b0;
            r_div_sh    <= DIV_W'(DEFAULT_DIV);
            r_par_en_sh <= 1'b0;
            r_stop2_sh  <= 1'b0;
            r_rdata     <= '0;
        end else if (w_soft_rst) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_status    <= '0;
            r_div       <= DIV_W'(DEFAULT_DIV);
            r_par_en    <= 1'b0;
            r_stop2     <= 1'b0;
            r_div_sh    <= DIV_W'(DEFAULT_DIV);
            r_par_en_sh <= 1'b0;
            r_stop2_sh  <= 1'b0;
            r_rdata     <= '0;
        end else begin
            if (w_rd) r_rdata <= w_rmux;
            if (w_wr && (w_off == ADDR_DIV))      r_div    <= w_div_wr;
            if (w_wr && (w_off == ADDR_PARITY))   r_par_en <= write_data_i[0];
            if (w_wr && (w_off == ADDR_STOPBITS)) r_stop2  <= write_data_i[0];
            if (w_cfg_load) begin
                r_div_sh    <= r_div;
                r_par_en_sh <= r_par_en;
                r_stop2_sh  <= r_stop2;
            end
            if (w_byte_valid) begin
                r_data  <= w_byte;
                r_valid <= 1'b1;
            end else if (w_data_rd) begin
                r_valid <= 1'b0;
            end
            r_status <= (r_status & ~w_status_clr) | w_status_set;
        end
    end

    uart_rx #(
        .DIV_W(DIV_W)
    ) u_rx (
        .i_clk        (clk_i),
        .i_rst_n      (resetn_i),
        .i_clr        (w_soft_rst),
        .i_rx         (rx_i),
        .i_div        (r_div),
        .i_div_sh     (r_div_sh),
        .i_par_en_sh  (r_par_en_sh),
        .i_stop2_sh   (r_stop2_sh),
        .o_cfg_load   (w_cfg_load),
        .o_byte       (w_byte),
        .o_byte_valid (w_byte_valid),
        .o_frame_err  (w_frame_err),
        .o_parity_err (w_parity_err),
        .o_busy       (w_busy)
    );

    assign read_data_o = r_rdata;
    assign irq_req_o   = r_valid;

endmodule

// File: tb/tb_uart_rx_sb_ctrl.sv
// Self-checking bench for uart_rx_sb_ctrl: serial frames are driven on rx_i, received bytes are
// queued as expectations and compared against DATA reads over the bus.
module tb_uart_rx_sb_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rx;
    logic        irq;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  exp_data = 8'h00;
    logic [31:0] rd;

    uart_rx_sb_ctrl #(
        .DEFAULT_DIV (1042),
        .DIV_W       (16)
    ) dut (
        .clk_i          (clk),
        .resetn_i       (resetn),
        .req_i          (req),
        .write_enable_i (we),
        .addr_i         (addr),
        .write_data_i   (wdata),
        .read_data_o    (rdata),
        .rx_i           (rx),
        .irq_req_o      (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // All bus tasks start and end on a falling edge.
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        req = 1'b0; we = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        req = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        req = 1'b0;
        d = rdata;
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] v;
        bus_read(a, v);
        check(tag, v, exp);
    endtask

    // DATA holds the newest committed byte; older unread bytes were overwritten.
    task automatic read_data_check(input string tag);
        logic [31:0] v;
        if (exp_q.size() > 0) begin
            exp_data = exp_q[$];
            exp_q.delete();
        end
        bus_read(32'h00, v);
        check(tag, v, {24'h0, exp_data});
    endtask

    task automatic send_frame(input logic [7:0] b, input bit par_en, input bit par_val,
                              input int nstop, input bit stop_val, input int div);
        rx = 1'b0;
        repeat (div) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (div) @(negedge clk);
        end
        if (par_en) begin
            rx = par_val;
            repeat (div) @(negedge clk);
        end
        for (int s = 0; s < nstop; s++) begin
            rx = stop_val;
            repeat (div) @(negedge clk);
        end
        rx = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [7:0] partial;
        resetn = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; rx = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_rdata", rdata, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        resetn = 1'b1;
        @(negedge clk);
        read_check("rst_div", 32'h0C, 32'd1042);
        read_check("rst_valid", 32'h04, 32'h0);
        read_check("rst_status", 32'h18, 32'h0);
        read_check("rst_busy", 32'h08, 32'h0);
        read_check("unmapped_20", 32'h20, 32'h0);

        // DIV clamp boundary: below 16 clamps, 16 itself is kept.
        bus_write(32'h0C, 32'd5);
        read_check("div_clamp", 32'h0C, 32'd16);
        bus_write(32'h0C, 32'd16);
        read_check("div_16", 32'h0C, 32'd16);

        // Baseline 8N1 frame.
        send_frame(8'hA5, 1'b0, 1'b0, 1, 1'b1, 16);
        exp_q.push_back(8'hA5);
        check("base_irq", {31'h0, irq}, 32'h1);
        read_check("base_valid", 32'h04, 32'h1);
        read_data_check("base_data");
        read_check("base_valid_clr", 32'h04, 32'h0);
        check("base_irq_clr", {31'h0, irq}, 32'h0);

        // Start-bit glitch.
        rx = 1'b0;
        repeat (3) @(negedge clk);
        read_check("glitch_busy_hi", 32'h08, 32'h1);
        @(negedge clk);
        rx = 1'b1;
        repeat (16) @(negedge clk);
        read_check("glitch_busy_lo", 32'h08, 32'h0);
        read_check("glitch_valid", 32'h04, 32'h0);
        read_check("glitch_status", 32'h18, 32'h0);

        // Overrun.
        send_frame(8'h11, 1'b0, 1'b0, 1, 1'b1, 16);
        exp_q.push_back(8'h11);
        send_frame(8'h22, 1'b0, 1'b0, 1, 1'b1, 16);
        exp_q.push_back(8'h22);
        read_check("ovr_status", 32'h18, 32'h1);
        read_data_check("ovr_data");
        bus_write(32'h18, 32'h1);
        read_check("ovr_w1c", 32'h18, 32'h0);

        // Frame error: byte discarded, DATA keeps the previous byte.
        send_frame(8'h3C, 1'b0, 1'b0, 1, 1'b0, 16);
        read_check("frm_valid", 32'h04, 32'h0);
        read_check("frm_status", 32'h18, 32'h2);
        read_data_check("frm_data");
        bus_write(32'h18, 32'h7);

        // Parity error with two stop bits; 0x07 needs parity 1.
        bus_write(32'h10, 32'h1);
        bus_write(32'h14, 32'h1);
        read_check("par_en_rb", 32'h10, 32'h1);
        send_frame(8'h07, 1'b1, 1'b0, 2, 1'b1, 16);
        exp_q.push_back(8'h07);
        read_check("par_valid", 32'h04, 32'h1);
        read_check("par_status", 32'h18, 32'h4);
        read_data_check("par_data");
        send_frame(8'h03, 1'b1, 1'b0, 2, 1'b1, 16);
        exp_q.push_back(8'h03);
        read_check("par_ok_status", 32'h18, 32'h4);
        read_data_check("par_ok_data");

        // Soft reset restores every register.
        bus_write(32'h24, 32'h1);
        exp_data = 8'h00;
        read_check("srst_div", 32'h0C, 32'd1042);
        read_check("srst_par", 32'h10, 32'h0);
        read_check("srst_stop", 32'h14, 32'h0);
        read_check("srst_status", 32'h18, 32'h0);
        read_data_check("srst_data");

        // Hard reset mid-frame after data bit 3, with a DIV write in flight.
        bus_write(32'h0C, 32'd16);
        partial = 8'h96;
        rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx = partial[i];
            if (i == 1) begin
                bus_write(32'h0C, 32'd32);
                repeat (15) @(negedge clk);
            end else begin
                repeat (16) @(negedge clk);
            end
        end
        resetn = 1'b0;
        rx = 1'b1;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        exp_data = 8'h00;
        repeat (4) @(negedge clk);
        read_check("hrst_div", 32'h0C, 32'd1042);
        read_check("hrst_busy", 32'h08, 32'h0);
        read_check("hrst_valid", 32'h04, 32'h0);
        send_frame(8'h5A, 1'b0, 1'b0, 1, 1'b1, 1042);
        exp_q.push_back(8'h5A);
        check("hrst_irq", {31'h0, irq}, 32'h1);
        read_data_check("hrst_data");
        read_check("hrst_status", 32'h18, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
